// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader.
//   state_t       : loader FSM states (S_CHECK only reachable with LOADER_CHECKSUM_EN)
//   SYNC_BYTE_DEF : default frame start marker
//   RECORD_BYTES  : stream bytes per record (INSTR, A_HI, A_LO, B_HI, B_LO)
//   CNT_W         : width of the record-count byte
package program_loader_pkg;

  localparam int         RECORD_BYTES  = 5;
  localparam int         CNT_W         = 8;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_COUNT,
    S_INSTR,
    S_A_HI,
    S_A_LO,
    S_B_HI,
    S_B_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/program_loader_checksum.sv
// loader_checksum: 8-bit running XOR over accepted frame bytes.
// Only built when LOADER_CHECKSUM_EN is defined.
//   clk, reset : clock, async active-low reset
//   clear      : zero the running sum (frame start)
//   accum      : fold data into the sum this cycle
//   data       : byte to fold / byte being tested against the sum
//   sum        : current running XOR
//   zero       : 1 when sum ^ data == 0 (data is a matching checksum byte)
`ifdef LOADER_CHECKSUM_EN
module loader_checksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       accum,
  input  logic [7:0] data,
  output logic [7:0] sum,
  output logic       zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= 8'h00;
    end else if (clear) begin
      sum <= 8'h00;
    end else if (accum) begin
      sum <= sum ^ data;
    end
  end

  assign zero = ((sum ^ data) == 8'h00);

endmodule
`endif

// File: rtl/program_loader.sv
// program_loader: parses a framed byte stream (SYNC, CNT, CNT+1 x 5-byte
// records) and writes each record {instr, a, b} at an incrementing PC address.
// The CPU is held until a complete, valid frame has been stored.
// Optional: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHECK state).
//   clk, reset      : clock, async active-low reset
//   in_data/valid   : stream byte in; in_ready is the loader's accept
//   mem_we          : one-cycle store write strobe with mem_addr/instr/a/b
//   cpu_hold        : keeps the CPU PC in reset until DONE
//   load_done       : level, frame loaded
//   load_error      : sticky until the next SYNC byte
//   records_loaded  : records written in the current frame
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_W    = 4,
  parameter int         INSTR_W   = 8,
  parameter int         DATA_W    = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_instr,
  output logic [DATA_W-1:0]  mem_a,
  output logic [DATA_W-1:0]  mem_b,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_error,
  output logic [ADDR_W:0]    records_loaded
);

  state_t               state, state_nx;
  logic                 armed;
  logic [ADDR_W-1:0]    addr, last;
  logic [INSTR_W-1:0]   instr_q;
  logic [DATA_W-1:0]    a_q, b_q;
  logic [ADDR_W:0]      rec_q;
  logic                 xfer, start, resync_ok, cnt_bad;

  assign xfer      = in_valid & in_ready;
  assign resync_ok = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign start     = xfer & resync_ok & (in_data == SYNC_BYTE);
  // Any set bit above the address field means more records than the store holds.
  assign cnt_bad   = ((in_data >> ADDR_W) != 8'h00);

`ifdef LOADER_CHECKSUM_EN
  logic       ck_accum, ck_zero;
  logic [7:0] ck_sum;

  assign ck_accum = xfer && (state inside {S_COUNT, S_INSTR, S_A_HI, S_A_LO, S_B_HI, S_B_LO});

  loader_checksum u_checksum (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .accum (ck_accum),
    .data  (in_data),
    .sum   (ck_sum),
    .zero  (ck_zero)
  );
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nx = S_COUNT;
      S_COUNT: if (xfer) state_nx = cnt_bad ? S_ERROR : S_INSTR;
      S_INSTR: if (xfer) state_nx = S_A_HI;
      S_A_HI:  if (xfer) state_nx = S_A_LO;
      S_A_LO:  if (xfer) state_nx = S_B_HI;
      S_B_HI:  if (xfer) state_nx = S_B_LO;
      S_B_LO:  if (xfer) state_nx = S_WRITE;
      S_WRITE: begin
        if (addr == last) begin
`ifdef LOADER_CHECKSUM_EN
          state_nx = S_CHECK;
`else
          state_nx = S_DONE;
`endif
        end else begin
          state_nx = S_INSTR;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: if (xfer) state_nx = ck_zero ? S_DONE : S_ERROR;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      armed   <= 1'b0;
      addr    <= '0;
      last    <= '0;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rec_q   <= '0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      if (start) rec_q <= '0;
      if (xfer) begin
        case (state)
          S_COUNT: begin
            last <= in_data[ADDR_W-1:0];
            addr <= '0;
          end
          S_INSTR: instr_q          <= in_data[INSTR_W-1:0];
          S_A_HI:  a_q[DATA_W-1:8]  <= in_data;
          S_A_LO:  a_q[7:0]         <= in_data;
          S_B_HI:  b_q[DATA_W-1:8]  <= in_data;
          S_B_LO:  b_q[7:0]         <= in_data;
          default: ;
        endcase
      end
      if (state == S_WRITE) begin
        rec_q <= rec_q + {{ADDR_W{1'b0}}, 1'b1};
        if (addr != last) addr <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // armed keeps in_ready low while reset is asserted and until the first clock after release.
  assign in_ready       = armed && (state != S_WRITE);
  assign mem_we         = (state == S_WRITE);
  assign mem_addr       = addr;
  assign mem_instr      = instr_q;
  assign mem_a          = a_q;
  assign mem_b          = b_q;
  assign cpu_hold       = (state != S_DONE);
  assign load_done      = (state == S_DONE);
  assign load_error     = (state == S_ERROR);
  assign records_loaded = rec_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, cpu_hold, load_done, load_error;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_instr;
  logic [15:0] mem_a, mem_b;
  logic [4:0]  records_loaded;

  program_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_instr(mem_instr), .mem_a(mem_a), .mem_b(mem_b),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .records_loaded(records_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  addr;
    logic [7:0]  instr;
    logic [15:0] a;
    logic [15:0] b;
  } wr_t;

  int   errors = 0;
  int   checks = 0;
  int   writes_seen = 0;
  wr_t  exp_q[$];
  wr_t  last_wr;
  logic [7:0]  r_instr [16];
  logic [15:0] r_a [16];
  logic [15:0] r_b [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every cycle out of reset: hold/done relation and each write against the model queue.
  always @(negedge clk) begin
    if (reset) begin
      chk("hold_vs_done", 64'(cpu_hold), 64'(!load_done));
      if (mem_we) begin
        writes_seen++;
        last_wr = {mem_addr, mem_instr, mem_a, mem_b};
        chk("ready_low_in_write", 64'(in_ready), 64'd0);
        if (exp_q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
        else chk("write_word", 64'(last_wr), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_bytes(input logic [7:0] s[$], input bit gaps);
    bit   taken;
    logic rdy;
    foreach (s[k]) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        in_data  = 8'hA5;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_data  = s[k];
      in_valid = 1'b1;
      taken    = 1'b0;
      for (int n = 0; n < 16 && !taken; n++) begin
        rdy = in_ready;
        @(negedge clk);
        if (rdy) taken = 1'b1;
      end
      if (!taken) chk("ready_timeout", 64'd0, 64'd1);
    end
    in_valid = 1'b0;
  endtask

  // Builds a frame from r_* tables, queues the writes it must produce, sends it,
  // then checks the end-of-frame status.
  task automatic frame(input int cnt, input bit gaps, input bit bad_ck);
    logic [7:0] s[$];
    logic [7:0] x;
    bit         ok;
    s.push_back(8'hA5);
    s.push_back(8'(cnt));
    x = 8'(cnt);
    if (cnt <= 15) begin
      for (int i = 0; i <= cnt; i++) begin
        s.push_back(r_instr[i]);
        s.push_back(r_a[i][15:8]); s.push_back(r_a[i][7:0]);
        s.push_back(r_b[i][15:8]); s.push_back(r_b[i][7:0]);
        x = x ^ r_instr[i] ^ r_a[i][15:8] ^ r_a[i][7:0] ^ r_b[i][15:8] ^ r_b[i][7:0];
        exp_q.push_back({4'(i), r_instr[i], r_a[i], r_b[i]});
      end
    end
    ok = (cnt <= 15);
`ifdef LOADER_CHECKSUM_EN
    if (cnt <= 15) s.push_back(bad_ck ? (x ^ 8'h01) : x);
    if (bad_ck) ok = 1'b0;
`endif
    send_bytes(s, gaps);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    chk("load_done", 64'(load_done), 64'(ok));
    chk("load_error", 64'(load_error), 64'(!ok));
    chk("cpu_hold", 64'(cpu_hold), 64'(!ok));
    chk("records_loaded", 64'(records_loaded), (cnt <= 15) ? 64'(cnt + 1) : 64'd0);
  endtask

  task automatic fill_case2(input bit a5_data);
    r_instr[0] = a5_data ? 8'hA5 : 8'h12;
    r_a[0]     = a5_data ? 16'hA5CD : 16'hABCD;
    r_b[0]     = a5_data ? 16'h00A5 : 16'h0001;
  endtask

  task automatic fill_case3();
    for (int i = 0; i < 16; i++) begin
      r_instr[i] = 8'(i * 3 + 7);
      r_a[i]     = 16'(16'h1000 + i * 257);
      r_b[i]     = ~r_a[i];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    logic [7:0] s[$];

    // 1: reset behaviour
    repeat (3) @(negedge clk);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_done_err", 64'({load_done, load_error}), 64'd0);
    chk("rst_rec", 64'(records_loaded), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'd1);
    chk("idle_hold", 64'(cpu_hold), 64'd1);
    chk("idle_outs", 64'({mem_we, load_done, load_error, mem_addr, mem_instr, mem_a, mem_b, records_loaded}), 64'd0);

    // 2: single record, literal pins
    fill_case2(1'b0);
    w0 = writes_seen;
    frame(0, 1'b0, 1'b0);
    chk("t2_writes", 64'(writes_seen - w0), 64'd1);
    chk("t2_addr", 64'(last_wr.addr), 64'h0);
    chk("t2_instr", 64'(last_wr.instr), 64'h12);
    chk("t2_a", 64'(last_wr.a), 64'hABCD);
    chk("t2_b", 64'(last_wr.b), 64'h0001);

    // junk byte in DONE is dropped
    s = {8'h3C};
    send_bytes(s, 1'b0);
    repeat (2) @(negedge clk);
    chk("done_junk", 64'({load_done, cpu_hold, records_loaded}), 64'b1_0_00001);

    // 3: sixteen records
    fill_case3();
    w0 = writes_seen;
    frame(15, 1'b0, 1'b0);
    chk("t3_writes", 64'(writes_seen - w0), 64'd16);
    chk("t3_last_addr", 64'(last_wr.addr), 64'hF);

    // 4: oversize count, then recovery
    w0 = writes_seen;
    frame(16, 1'b0, 1'b0);
    chk("t4_no_write", 64'(writes_seen - w0), 64'd0);
    fill_case2(1'b0);
    frame(0, 1'b0, 1'b0);

    // 5: gappy in_valid with A5 as data, then gappy 16-record frame
    fill_case2(1'b1);
    frame(0, 1'b1, 1'b0);
    chk("t5_instr_a5", 64'(last_wr.instr), 64'hA5);
    fill_case3();
    frame(15, 1'b1, 1'b0);

    // 6: reset between A_LO and B_HI aborts without a write
    w0 = writes_seen;
    s = {8'hA5, 8'h01, 8'h11, 8'h22, 8'h33};
    send_bytes(s, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_we", 64'(mem_we), 64'd0);
    chk("abort_hold", 64'(cpu_hold), 64'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_write", 64'(writes_seen - w0), 64'd0);
    chk("abort_idle", 64'({load_done, load_error, records_loaded}), 64'd0);
    fill_case2(1'b0);
    frame(0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    fill_case3();
    frame(2, 1'b0, 1'b1);
    frame(2, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
